// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: tracks register writers in DEPTH stages behind ID,
// picks forwarding sources, detects load-use stalls and counts stall cycles.

module hazard_src_match #(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int RA_W     = 5
) (
    input  logic                       id_valid,
    input  logic                       use_rs,
    input  logic [RA_W-1:0]            rs,
    input  logic [DEPTH-1:0]           wr_vld,
    input  logic [DEPTH-1:0][RA_W-1:0] wr_rd,
    input  logic [DEPTH-1:0]           wr_load,
    output logic [3:0]                 fwd_sel,
    output logic                       hazard
);
    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        fwd_sel = '0;
        hazard  = 1'b0;
        if (id_valid && use_rs && rs != '0) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (wr_vld[k] && wr_rd[k] == rs) begin
                    fwd_sel = 4'(k + 1);
                    hazard  = wr_load[k] && (k < LOAD_LAT);
                end
            end
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int RA_W     = 5,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ID_VALID,
    input  logic [RA_W-1:0]  ID_RS1,
    input  logic [RA_W-1:0]  ID_RS2,
    input  logic             ID_USE_RS1,
    input  logic             ID_USE_RS2,
    input  logic [RA_W-1:0]  ID_RD,
    input  logic             ID_REGWRITE,
    input  logic             ID_IS_LOAD,
    input  logic             FLUSH,
    output logic             STALL_ID,
    output logic [3:0]       FWD_SEL1,
    output logic [3:0]       FWD_SEL2,
    output logic [3:0]       INFLIGHT,
    output logic [CNT_W-1:0] STALL_CNT
);
    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            is_load;
    } slot_t;

    slot_t [DEPTH-1:0]       slot_q, slot_d;
    logic  [3:0]             inflight_q, inflight_d;
    logic  [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

    logic [DEPTH-1:0]           wr_vld;
    logic [DEPTH-1:0][RA_W-1:0] wr_rd;
    logic [DEPTH-1:0]           wr_load;
    logic [1:0][RA_W-1:0]       rs_v;
    logic [1:0]                 use_v;
    logic [1:0][3:0]            fwd_v;
    logic [1:0]                 haz_v;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            wr_vld[k]  = slot_q[k].valid && slot_q[k].regwrite && (slot_q[k].rd != '0);
            wr_rd[k]   = slot_q[k].rd;
            wr_load[k] = slot_q[k].is_load;
        end
    end

    assign rs_v  = {ID_RS2, ID_RS1};
    assign use_v = {ID_USE_RS2, ID_USE_RS1};

    genvar n;
    generate
        for (n = 0; n < 2; n++) begin : g_src
            hazard_src_match #(
                .DEPTH   (DEPTH),
                .LOAD_LAT(LOAD_LAT),
                .RA_W    (RA_W)
            ) u_match (
                .id_valid(ID_VALID),
                .use_rs  (use_v[n]),
                .rs      (rs_v[n]),
                .wr_vld  (wr_vld),
                .wr_rd   (wr_rd),
                .wr_load (wr_load),
                .fwd_sel (fwd_v[n]),
                .hazard  (haz_v[n])
            );
        end
    endgenerate

    // Flush wins over a hazard: the killed instruction must not hold the front end.
    assign STALL_ID = ID_VALID && !FLUSH && (|haz_v);
    assign FWD_SEL1 = fwd_v[0];
    assign FWD_SEL2 = fwd_v[1];

    always_comb begin
        slot_d[0].valid    = ID_VALID && !FLUSH && !STALL_ID;
        slot_d[0].rd       = ID_RD;
        slot_d[0].regwrite = ID_REGWRITE;
        slot_d[0].is_load  = ID_IS_LOAD;
        for (int k = 1; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k-1];
        end
        inflight_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            inflight_d = inflight_d + {3'b000, slot_d[k].valid};
        end
        stall_cnt_d = stall_cnt_q;
        if (STALL_ID && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_q      <= '0;
            inflight_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            inflight_q  <= inflight_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign INFLIGHT  = inflight_q;
    assign STALL_CNT = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: default instance plus a DEPTH=5/LOAD_LAT=2/CNT_W=4 one.

module tb_hazard_scoreboard;
    typedef struct packed {
        logic       rst, flush, valid;
        logic [4:0] rs1, rs2;
        logic       use1, use2;
        logic [4:0] rd;
        logic       rw, ld;
    } stim_t;

    typedef struct packed {
        int stall, f1, f2, infl, scnt;
    } row_exp_t;

    typedef struct packed {
        int          kind;
        logic [31:0] val;
    } sb_t;

    logic       CLK, RST, ID_VALID, ID_USE_RS1, ID_USE_RS2, ID_REGWRITE, ID_IS_LOAD, FLUSH;
    logic [4:0] ID_RS1, ID_RS2, ID_RD;
    logic       stall_a, stall_b;
    logic [3:0] f1_a, f2_a, infl_a, f1_b, f2_b, infl_b;
    logic [31:0] scnt_a;
    logic [3:0]  scnt_b;

    sb_t      exp_q[$];
    stim_t    st_q[$];
    row_exp_t ex_q[$];
    int       n_chk = 0;
    int       n_fail = 0;
    string    cur_test;

    hazard_scoreboard dut_a (
        .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2), .ID_RD(ID_RD),
        .ID_REGWRITE(ID_REGWRITE), .ID_IS_LOAD(ID_IS_LOAD), .FLUSH(FLUSH),
        .STALL_ID(stall_a), .FWD_SEL1(f1_a), .FWD_SEL2(f2_a), .INFLIGHT(infl_a),
        .STALL_CNT(scnt_a)
    );

    hazard_scoreboard #(.DEPTH(5), .LOAD_LAT(2), .RA_W(5), .CNT_W(4)) dut_b (
        .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2), .ID_RD(ID_RD),
        .ID_REGWRITE(ID_REGWRITE), .ID_IS_LOAD(ID_IS_LOAD), .FLUSH(FLUSH),
        .STALL_ID(stall_b), .FWD_SEL1(f1_b), .FWD_SEL2(f2_b), .INFLIGHT(infl_b),
        .STALL_CNT(scnt_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic stim_t ins(int v, int rs1, int u1, int rs2, int u2, int rd, int rw, int ld);
        stim_t s;
        s = '0;
        s.valid = v[0];
        s.rs1 = 5'(rs1); s.use1 = u1[0];
        s.rs2 = 5'(rs2); s.use2 = u2[0];
        s.rd = 5'(rd); s.rw = rw[0]; s.ld = ld[0];
        return s;
    endfunction

    function automatic stim_t with_flush(stim_t s);
        stim_t r;
        r = s;
        r.flush = 1'b1;
        return r;
    endfunction

    function automatic stim_t with_rst(stim_t s);
        stim_t r;
        r = s;
        r.rst = 1'b1;
        return r;
    endfunction

    function automatic row_exp_t ex(int stall, int f1, int f2, int infl, int scnt);
        row_exp_t e;
        e.stall = stall; e.f1 = f1; e.f2 = f2; e.infl = infl; e.scnt = scnt;
        return e;
    endfunction

    function automatic string kname(int k);
        case (k)
            0: return "STALL_ID";
            1: return "FWD_SEL1";
            2: return "FWD_SEL2";
            3: return "INFLIGHT";
            4: return "STALL_CNT";
            5: return "b.STALL_ID";
            6: return "b.FWD_SEL1";
            7: return "b.FWD_SEL2";
            8: return "b.INFLIGHT";
            default: return "b.STALL_CNT";
        endcase
    endfunction

    function automatic logic [31:0] observe(int k);
        case (k)
            0: return {31'b0, stall_a};
            1: return {28'b0, f1_a};
            2: return {28'b0, f2_a};
            3: return {28'b0, infl_a};
            4: return scnt_a;
            5: return {31'b0, stall_b};
            6: return {28'b0, f1_b};
            7: return {28'b0, f2_b};
            8: return {28'b0, infl_b};
            default: return {28'b0, scnt_b};
        endcase
    endfunction

    task automatic add(stim_t s, row_exp_t e);
        st_q.push_back(s);
        ex_q.push_back(e);
    endtask

    task automatic push_one(int kind, int val);
        sb_t item;
        item.kind = kind;
        item.val  = val;
        if (val >= 0) exp_q.push_back(item);
    endtask

    // Drives one cycle of ID inputs and queues the values expected during that cycle.
    task automatic drive(stim_t s, row_exp_t e, int dut);
        int base;
        base = (dut == 2) ? 5 : 0;
        RST = s.rst; FLUSH = s.flush; ID_VALID = s.valid;
        ID_RS1 = s.rs1; ID_RS2 = s.rs2; ID_USE_RS1 = s.use1; ID_USE_RS2 = s.use2;
        ID_RD = s.rd; ID_REGWRITE = s.rw; ID_IS_LOAD = s.ld;
        push_one(base + 0, e.stall);
        push_one(base + 1, e.f1);
        push_one(base + 2, e.f2);
        push_one(base + 3, e.infl);
        push_one(base + 4, e.scnt);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic row_exp_t none();
        return ex(-1, -1, -1, -1, -1);
    endfunction

    task automatic test_reset();
        sb_t e; logic [31:0] obs;
        cur_test = "reset"; st_q.delete(); ex_q.delete();
        add(with_rst(ins(1, 1, 1, 2, 1, 3, 1, 0)), none());
        add(ins(1, 1, 1, 2, 1, 3, 1, 0), ex(0, 0, 0, 0, 0));
        for (int i = 0; i < st_q.size(); i++) begin
            drive(st_q[i], ex_q[i], 1);
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); obs = observe(e.kind); n_chk++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s %s cycle %0d: got %0d, expected %0d", cur_test, kname(e.kind), i, obs, e.val);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        sb_t e; logic [31:0] obs;
        cur_test = "back_to_back"; st_q.delete(); ex_q.delete();
        add(with_rst(ins(0, 0, 0, 0, 0, 0, 0, 0)), none());
        add(ins(1, 0, 0, 0, 0, 1, 1, 0), ex(0, 0, 0, 0, 0));
        add(ins(1, 1, 1, 3, 1, 2, 1, 0), ex(0, 1, 0, 1, -1));
        add(ins(1, 1, 1, 2, 1, 0, 0, 0), ex(0, 2, 1, 2, -1));
        add(ins(0, 1, 1, 2, 1, 0, 0, 0), ex(0, 0, 0, 3, -1));
        add(ins(0, 0, 0, 0, 0, 0, 0, 0), ex(-1, -1, -1, 2, 0));
        for (int i = 0; i < st_q.size(); i++) begin
            drive(st_q[i], ex_q[i], 1);
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); obs = observe(e.kind); n_chk++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s %s cycle %0d: got %0d, expected %0d", cur_test, kname(e.kind), i, obs, e.val);
                end
            end
            step();
        end
    endtask

    task automatic test_load_use();
        sb_t e; logic [31:0] obs;
        cur_test = "load_use"; st_q.delete(); ex_q.delete();
        add(with_rst(ins(0, 0, 0, 0, 0, 0, 0, 0)), none());
        add(ins(1, 0, 0, 0, 0, 5, 1, 1), ex(0, 0, 0, 0, 0));
        add(ins(1, 5, 1, 5, 1, 6, 1, 0), ex(1, 1, 1, 1, 0));
        add(ins(1, 5, 1, 5, 1, 6, 1, 0), ex(0, 2, 2, 1, 1));
        add(ins(0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 2, 1));
        add(ins(0, 0, 0, 0, 0, 0, 0, 0), ex(-1, -1, -1, 1, 1));
        for (int i = 0; i < st_q.size(); i++) begin
            drive(st_q[i], ex_q[i], 1);
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); obs = observe(e.kind); n_chk++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s %s cycle %0d: got %0d, expected %0d", cur_test, kname(e.kind), i, obs, e.val);
                end
            end
            step();
        end
    endtask

    task automatic test_x0_youngest();
        sb_t e; logic [31:0] obs;
        cur_test = "x0_youngest"; st_q.delete(); ex_q.delete();
        add(with_rst(ins(0, 0, 0, 0, 0, 0, 0, 0)), none());
        add(ins(1, 0, 0, 0, 0, 0, 1, 0), ex(0, 0, 0, 0, -1));
        add(ins(1, 0, 1, 0, 1, 0, 0, 0), ex(0, 0, 0, 1, -1));
        add(ins(1, 0, 0, 0, 0, 7, 1, 0), ex(0, 0, 0, 2, -1));
        add(ins(1, 0, 0, 0, 0, 7, 0, 0), ex(0, 0, 0, 3, -1));
        add(ins(1, 7, 1, 0, 0, 7, 1, 0), ex(0, 2, 0, 3, -1));
        add(ins(1, 7, 1, 7, 0, 0, 0, 0), ex(0, 1, 0, 3, -1));
        add(ins(1, 7, 1, 7, 1, 0, 0, 0), ex(0, 2, 2, 3, -1));
        for (int i = 0; i < st_q.size(); i++) begin
            drive(st_q[i], ex_q[i], 1);
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); obs = observe(e.kind); n_chk++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s %s cycle %0d: got %0d, expected %0d", cur_test, kname(e.kind), i, obs, e.val);
                end
            end
            step();
        end
    endtask

    task automatic test_flush_hazard();
        sb_t e; logic [31:0] obs;
        cur_test = "flush_hazard"; st_q.delete(); ex_q.delete();
        add(with_rst(ins(0, 0, 0, 0, 0, 0, 0, 0)), none());
        add(ins(1, 0, 0, 0, 0, 5, 1, 1), ex(0, 0, 0, 0, 0));
        add(with_flush(ins(1, 5, 1, 0, 0, 6, 1, 0)), ex(0, 1, 0, 1, 0));
        add(ins(0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0));
        add(ins(0, 0, 0, 0, 0, 0, 0, 0), ex(-1, -1, -1, 1, 0));
        add(ins(0, 0, 0, 0, 0, 0, 0, 0), ex(-1, -1, -1, 0, 0));
        for (int i = 0; i < st_q.size(); i++) begin
            drive(st_q[i], ex_q[i], 1);
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); obs = observe(e.kind); n_chk++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s %s cycle %0d: got %0d, expected %0d", cur_test, kname(e.kind), i, obs, e.val);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        sb_t e; logic [31:0] obs;
        cur_test = "reset_mid"; st_q.delete(); ex_q.delete();
        add(with_rst(ins(0, 0, 0, 0, 0, 0, 0, 0)), none());
        add(ins(1, 0, 0, 0, 0, 1, 1, 0), ex(0, 0, 0, 0, 0));
        add(ins(1, 0, 0, 0, 0, 2, 1, 0), none());
        add(ins(1, 0, 0, 0, 0, 3, 1, 1), ex(-1, -1, -1, 2, -1));
        add(with_rst(ins(1, 3, 1, 1, 1, 4, 1, 0)), ex(1, 1, 3, 3, 0));
        add(ins(1, 3, 1, 1, 1, 4, 1, 0), ex(0, 0, 0, 0, 0));
        add(ins(0, 0, 0, 0, 0, 0, 0, 0), ex(-1, -1, -1, 1, 0));
        for (int i = 0; i < st_q.size(); i++) begin
            drive(st_q[i], ex_q[i], 1);
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); obs = observe(e.kind); n_chk++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s %s cycle %0d: got %0d, expected %0d", cur_test, kname(e.kind), i, obs, e.val);
                end
            end
            step();
        end
    endtask

    // Deep instance: 2-cycle load-use, then a self-dependent load chain saturates the 4-bit counter.
    task automatic test_param_sweep();
        sb_t e; logic [31:0] obs;
        int s;
        cur_test = "param_sweep"; st_q.delete(); ex_q.delete();
        add(with_rst(ins(0, 0, 0, 0, 0, 0, 0, 0)), none());
        add(ins(1, 0, 0, 0, 0, 5, 1, 1), ex(0, 0, 0, 0, 0));
        add(ins(1, 5, 1, 0, 0, 6, 1, 0), ex(1, 1, 0, 1, 0));
        add(ins(1, 5, 1, 0, 0, 6, 1, 0), ex(1, 2, 0, 1, 1));
        add(ins(1, 5, 1, 0, 0, 6, 1, 0), ex(0, 3, 0, 1, 2));
        s = 2;
        for (int i = 0; i < 32; i++) begin
            add(ins(1, 9, 1, 0, 0, 9, 1, 1),
                ex((i % 3 != 0) ? 1 : 0, (i == 0) ? 0 : ((i % 3 == 0) ? 3 : i % 3), 0, -1,
                   (s > 15) ? 15 : s));
            if (i % 3 != 0) s++;
        end
        for (int i = 0; i < st_q.size(); i++) begin
            drive(st_q[i], ex_q[i], 2);
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); obs = observe(e.kind); n_chk++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s %s cycle %0d: got %0d, expected %0d", cur_test, kname(e.kind), i, obs, e.val);
                end
            end
            step();
        end
    endtask

    initial begin
        RST = 1'b1; FLUSH = 1'b0; ID_VALID = 1'b0; ID_RS1 = '0; ID_RS2 = '0;
        ID_USE_RS1 = 1'b0; ID_USE_RS2 = 1'b0; ID_RD = '0; ID_REGWRITE = 1'b0; ID_IS_LOAD = 1'b0;
        step();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0_youngest();
        test_flush_hazard();
        test_reset_mid();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
